// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTN  = 32'h0000_0000;
    localparam logic [31:0] RESET_PC   = 32'd0;
    localparam logic [31:0] HALT_PC    = 32'd100;
    localparam int          IMEM_DEPTH = 1024;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC select: sequential advance with wrap, or an aligned
// redirect folded into the instruction-memory address space.
module pc_next_calc
    import if_pkg::*;
#(
    parameter int IMEM_DEPTH = 1024
) (
    input  logic [31:0] pc_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] next_pc_o,
    output logic        misaligned_o
);
    localparam logic [31:0] SPAN = 32'(IMEM_DEPTH * 4);

    logic [31:0] inc_s;

    assign inc_s        = pc_i + 32'd4;
    assign misaligned_o = (branch_target_i[1:0] != 2'b00);

    // Redirect beats sequential advance; advance wraps at the top of memory.
    always_comb begin
        next_pc_o = inc_s;
        if (branch_taken_i) begin
            next_pc_o = word_align(branch_target_i) % SPAN;
        end else if (inc_s == SPAN) begin
            next_pc_o = 32'd0;
        end else begin
            next_pc_o = inc_s;
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// IF-stage fetch sequencer: owns the PC, issues one word fetch per cycle to a
// synchronous instruction memory and hands valid-qualified pairs to IF/ID.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC   = if_pkg::RESET_PC,
    parameter logic [31:0] HALT_PC    = if_pkg::HALT_PC,
    parameter int          IMEM_DEPTH = if_pkg::IMEM_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_flag,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] imem_instn,
    output logic [31:0] pc,
    output logic        imem_stall,
    output logic [31:0] ifid_instn,
    output logic [31:0] ifid_pc,
    output logic        ifid_valid,
    output logic        halted,
    output logic        misaligned_err,
    output logic [31:0] fetch_count
);
    if_pkg::fetch_state_e state_q;

    logic [31:0] pc_q;
    logic [31:0] ifid_pc_q;
    logic [31:0] fetch_count_q;
    logic [31:0] fetch_count_d;
    logic [31:0] next_pc_s;
    logic        ifid_valid_q;
    logic        halted_q;
    logic        misaligned_q;
    logic        target_misaligned_s;
    logic        active_s;
    logic        consume_s;

    pc_next_calc #(
        .IMEM_DEPTH(IMEM_DEPTH)
    ) u_next (
        .pc_i           (pc_q),
        .branch_taken_i (branch_taken),
        .branch_target_i(branch_target),
        .next_pc_o      (next_pc_s),
        .misaligned_o   (target_misaligned_s)
    );

    assign active_s      = (state_q == if_pkg::RUN) || (state_q == if_pkg::STALL);
    // Sitting on HALT_PC in RUN must not launch a fetch, even before HALT is entered.
    assign imem_stall    = (state_q != if_pkg::RUN) | stall_flag | (pc_q == HALT_PC);
    assign consume_s     = ifid_valid_q & active_s & ~stall_flag & ~branch_taken;
    assign fetch_count_d = consume_s ? (fetch_count_q + 32'd1) : fetch_count_q;

    // Fetch FSM with its registered outputs; redirect beats stall beats advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= if_pkg::BOOT;
            pc_q          <= RESET_PC;
            ifid_pc_q     <= 32'd0;
            ifid_valid_q  <= 1'b0;
            halted_q      <= 1'b0;
            misaligned_q  <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
            case (state_q)
                if_pkg::BOOT: begin
                    state_q      <= if_pkg::RUN;
                    ifid_valid_q <= 1'b0;
                end
                if_pkg::RUN, if_pkg::STALL: begin
                    if (branch_taken) begin
                        pc_q         <= next_pc_s;
                        ifid_valid_q <= 1'b0;
                        state_q      <= if_pkg::RUN;
                        if (target_misaligned_s) begin
                            misaligned_q <= 1'b1;
                        end
                    end else if (stall_flag) begin
                        state_q <= if_pkg::STALL;
                    end else if (state_q == if_pkg::STALL) begin
                        // Release cycle: memory was not fetching, so nothing new arrives.
                        state_q      <= if_pkg::RUN;
                        ifid_valid_q <= 1'b0;
                    end else if (pc_q == HALT_PC) begin
                        state_q      <= if_pkg::HALT;
                        halted_q     <= 1'b1;
                        ifid_valid_q <= 1'b0;
                    end else begin
                        ifid_pc_q    <= pc_q;
                        ifid_valid_q <= 1'b1;
                        pc_q         <= next_pc_s;
                    end
                end
                if_pkg::HALT: begin
                    ifid_valid_q <= 1'b0;
                end
                default: begin
                    state_q      <= if_pkg::BOOT;
                    ifid_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc             = pc_q;
    assign ifid_pc        = ifid_pc_q;
    assign ifid_valid     = ifid_valid_q;
    assign ifid_instn     = ifid_valid_q ? imem_instn : if_pkg::NOP_INSTN;
    assign halted         = halted_q;
    assign misaligned_err = misaligned_q;
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios plus a randomized run
// against a cycle-level reference model, and a small-memory wrap instance.
module tb_pc_fetch_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        rst_n, stall_flag, branch_taken;
    logic [31:0] branch_target, imem_instn;
    logic [31:0] pc, ifid_instn, ifid_pc, fetch_count;
    logic        imem_stall, ifid_valid, halted, misaligned_err;
    logic [31:0] mem [0:1023];

    logic        w_rst_n, w_stall, w_br;
    logic [31:0] w_tgt, w_instn;
    logic [31:0] w_pc, w_ifid_instn, w_ifid_pc, w_count;
    logic        w_imem_stall, w_valid, w_halted, w_mis;
    logic [31:0] wmem [0:3];

    pc_fetch_sequencer u_dut (
        .clk(clk), .reset(rst_n), .stall_flag(stall_flag), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_instn(imem_instn), .pc(pc),
        .imem_stall(imem_stall), .ifid_instn(ifid_instn), .ifid_pc(ifid_pc),
        .ifid_valid(ifid_valid), .halted(halted), .misaligned_err(misaligned_err),
        .fetch_count(fetch_count)
    );

    pc_fetch_sequencer #(
        .RESET_PC(32'd0), .HALT_PC(32'hFFFF_FFFC), .IMEM_DEPTH(4)
    ) u_wrap (
        .clk(clk), .reset(w_rst_n), .stall_flag(w_stall), .branch_taken(w_br),
        .branch_target(w_tgt), .imem_instn(w_instn), .pc(w_pc),
        .imem_stall(w_imem_stall), .ifid_instn(w_ifid_instn), .ifid_pc(w_ifid_pc),
        .ifid_valid(w_valid), .halted(w_halted), .misaligned_err(w_mis),
        .fetch_count(w_count)
    );

    // Synchronous instruction memories: capture on an un-stalled edge, else hold.
    always @(posedge clk) begin
        if (!imem_stall) imem_instn <= mem[pc[11:2]];
        if (!w_imem_stall) w_instn <= wmem[w_pc[3:2]];
    end

    // Reference model state: what the fetch unit should present next cycle.
    bit          m_boot, m_halt, m_wait, m_dval, m_err;
    logic [31:0] m_pc, m_dpc, m_cnt;

    task automatic model_reset();
        m_boot = 1'b1; m_halt = 1'b0; m_wait = 1'b0; m_dval = 1'b0; m_err = 1'b0;
        m_pc = 32'd0; m_dpc = 32'd0; m_cnt = 32'd0;
    endtask

    task automatic model_step(input bit s, input bit b, input logic [31:0] t);
        bit live;
        live = !m_boot && !m_halt;
        if (live && m_dval && !s && !b) m_cnt = m_cnt + 32'd1;
        if (m_boot) begin
            m_boot = 1'b0; m_dval = 1'b0;
        end else if (m_halt) begin
            m_dval = 1'b0;
        end else if (b) begin
            m_pc = (t & 32'hFFFF_FFFC) % 32'd4096;
            m_dval = 1'b0; m_wait = 1'b0;
            if (t[1:0] != 2'b00) m_err = 1'b1;
        end else if (s) begin
            m_wait = 1'b1;
        end else if (m_wait) begin
            m_wait = 1'b0; m_dval = 1'b0;
        end else if (m_pc == 32'd100) begin
            m_halt = 1'b1; m_dval = 1'b0;
        end else begin
            m_dpc = m_pc; m_dval = 1'b1; m_pc = (m_pc + 32'd4) % 32'd4096;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall_flag = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
        @(negedge clk); @(negedge clk);
        total++; if (pc !== 32'd0) begin bad++; $display("FAIL reset_pc: got %0h want 0", pc); end
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", ifid_valid); end
        total++; if (ifid_pc !== 32'd0) begin bad++; $display("FAIL reset_ifid_pc: got %0h want 0", ifid_pc); end
        total++; if (ifid_instn !== 32'd0) begin bad++; $display("FAIL reset_instn: got %0h want 0", ifid_instn); end
        total++; if (halted !== 1'b0 || misaligned_err !== 1'b0) begin bad++; $display("FAIL reset_flags: got %0b%0b want 00", halted, misaligned_err); end
        total++; if (fetch_count !== 32'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
        total++; if (imem_stall !== 1'b1) begin bad++; $display("FAIL reset_imem_stall: got %0b want 1", imem_stall); end
        rst_n = 1'b1;
    endtask

    task automatic test_free_run();
        #1;
        total++; if (pc !== 32'd0 || imem_stall !== 1'b1) begin bad++; $display("FAIL boot: pc %0h stall %0b want 0/1", pc, imem_stall); end
        @(negedge clk);
        total++; if (pc !== 32'd0 || ifid_valid !== 1'b0 || imem_stall !== 1'b0) begin bad++; $display("FAIL run1: pc %0h valid %0b stall %0b want 0/0/0", pc, ifid_valid, imem_stall); end
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            total++; if (pc !== 32'(4 * (k - 1))) begin bad++; $display("FAIL free_pc: got %0d want %0d", pc, 4 * (k - 1)); end
            total++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'(4 * (k - 2)) || ifid_instn !== 32'(k - 2)) begin
                bad++; $display("FAIL free_deliver: got v%0b pc %0d instn %0d want v1 pc %0d instn %0d", ifid_valid, ifid_pc, ifid_instn, 4 * (k - 2), k - 2);
            end
            total++; if (fetch_count !== 32'(k - 2)) begin bad++; $display("FAIL free_count: got %0d want %0d", fetch_count, k - 2); end
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            stall_flag = 1'b1; #1;
            total++; if (imem_stall !== 1'b1) begin bad++; $display("FAIL stall_imem: got %0b want 1", imem_stall); end
            @(negedge clk);
            total++; if (pc !== 32'd12 || ifid_pc !== 32'd8 || ifid_valid !== 1'b1 || fetch_count !== 32'd2) begin
                bad++; $display("FAIL stall_hold: got pc %0d ifid_pc %0d v%0b cnt %0d want 12/8/1/2", pc, ifid_pc, ifid_valid, fetch_count);
            end
        end
        stall_flag = 1'b0; #1;
        total++; if (imem_stall !== 1'b1) begin bad++; $display("FAIL stall_release_imem: got %0b want 1", imem_stall); end
        @(negedge clk);
        total++; if (pc !== 32'd12 || fetch_count !== 32'd3) begin bad++; $display("FAIL stall_release: got pc %0d cnt %0d want 12/3", pc, fetch_count); end
        @(negedge clk);
        total++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'd12 || ifid_instn !== 32'd3) begin
            bad++; $display("FAIL stall_resume: got v%0b pc %0d instn %0d want 1/12/3", ifid_valid, ifid_pc, ifid_instn);
        end
    endtask

    task automatic test_branch();
        total++; if (pc !== 32'd16) begin bad++; $display("FAIL branch_pre: got pc %0d want 16", pc); end
        branch_taken = 1'b1; branch_target = 32'd40;
        @(negedge clk); branch_taken = 1'b0;
        total++; if (pc !== 32'd40 || ifid_valid !== 1'b0 || ifid_instn !== 32'd0) begin
            bad++; $display("FAIL branch_bubble: got pc %0d v%0b instn %0h want 40/0/0", pc, ifid_valid, ifid_instn);
        end
        total++; if (fetch_count !== 32'd3) begin bad++; $display("FAIL branch_count: got %0d want 3", fetch_count); end
        @(negedge clk);
        total++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'd40 || ifid_instn !== 32'd10) begin
            bad++; $display("FAIL branch_target: got v%0b pc %0d instn %0d want 1/40/10", ifid_valid, ifid_pc, ifid_instn);
        end
        @(negedge clk);
        stall_flag = 1'b1; branch_taken = 1'b1; branch_target = 32'd60;
        @(negedge clk); stall_flag = 1'b0; branch_taken = 1'b0;
        total++; if (pc !== 32'd60 || ifid_valid !== 1'b0) begin bad++; $display("FAIL branch_over_stall: got pc %0d v%0b want 60/0", pc, ifid_valid); end
        @(negedge clk);
        total++; if (ifid_pc !== 32'd60 || ifid_instn !== 32'd15) begin bad++; $display("FAIL branch_over_stall_deliver: got %0d/%0d want 60/15", ifid_pc, ifid_instn); end
    endtask

    task automatic test_misaligned();
        branch_taken = 1'b1; branch_target = 32'd42;
        @(negedge clk); branch_taken = 1'b0;
        total++; if (pc !== 32'd40 || misaligned_err !== 1'b1) begin bad++; $display("FAIL misalign: got pc %0d err %0b want 40/1", pc, misaligned_err); end
        @(negedge clk);
        total++; if (ifid_pc !== 32'd40 || ifid_instn !== 32'd10) begin bad++; $display("FAIL misalign_deliver: got %0d/%0d want 40/10", ifid_pc, ifid_instn); end
        @(negedge clk); @(negedge clk);
        total++; if (misaligned_err !== 1'b1) begin bad++; $display("FAIL misalign_sticky: got %0b want 1", misaligned_err); end
    endtask

    task automatic test_halt();
        logic [31:0] last;
        bit done;
        last = 32'hFFFF_FFFF; done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (ifid_valid) last = ifid_pc;
            if (halted) done = 1'b1;
        end
        total++; if (!done) begin bad++; $display("FAIL halt_timeout: got halted %0b want 1", halted); end
        total++; if (last !== 32'd96) begin bad++; $display("FAIL halt_last: got %0d want 96", last); end
        total++; if (pc !== 32'd100 || ifid_valid !== 1'b0 || imem_stall !== 1'b1) begin
            bad++; $display("FAIL halt_state: got pc %0d v%0b stall %0b want 100/0/1", pc, ifid_valid, imem_stall);
        end
        branch_taken = 1'b1; branch_target = 32'd8; stall_flag = 1'b1;
        @(negedge clk); @(negedge clk);
        total++; if (pc !== 32'd100 || halted !== 1'b1 || ifid_valid !== 1'b0) begin
            bad++; $display("FAIL halt_ignore: got pc %0d h%0b v%0b want 100/1/0", pc, halted, ifid_valid);
        end
        branch_taken = 1'b0; stall_flag = 1'b0;
        #2 rst_n = 1'b0; #1;
        total++; if (pc !== 32'd0 || halted !== 1'b0) begin bad++; $display("FAIL halt_reset: got pc %0d h%0b want 0/0", pc, halted); end
    endtask

    task automatic test_random();
        bit s, b;
        logic [31:0] t;
        bit exp_st;
        @(negedge clk);
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 300; i++) begin
            total++; if (pc !== m_pc) begin bad++; $display("FAIL rnd_pc: cyc %0d got %0h want %0h", i, pc, m_pc); end
            total++; if (ifid_valid !== m_dval) begin bad++; $display("FAIL rnd_valid: cyc %0d got %0b want %0b", i, ifid_valid, m_dval); end
            if (m_dval) begin
                total++; if (ifid_pc !== m_dpc) begin bad++; $display("FAIL rnd_ifid_pc: cyc %0d got %0h want %0h", i, ifid_pc, m_dpc); end
                total++; if (ifid_instn !== mem[m_dpc[11:2]]) begin bad++; $display("FAIL rnd_instn: cyc %0d got %0h want %0h", i, ifid_instn, mem[m_dpc[11:2]]); end
            end else begin
                total++; if (ifid_instn !== 32'd0) begin bad++; $display("FAIL rnd_nop: cyc %0d got %0h want 0", i, ifid_instn); end
            end
            total++; if (halted !== m_halt) begin bad++; $display("FAIL rnd_halted: cyc %0d got %0b want %0b", i, halted, m_halt); end
            total++; if (misaligned_err !== m_err) begin bad++; $display("FAIL rnd_err: cyc %0d got %0b want %0b", i, misaligned_err, m_err); end
            total++; if (fetch_count !== m_cnt) begin bad++; $display("FAIL rnd_count: cyc %0d got %0d want %0d", i, fetch_count, m_cnt); end
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 7) == 0);
            t = 32'($urandom_range(26, 1000)) << 2;
            if ($urandom_range(0, 5) == 0) t[1:0] = 2'($urandom_range(1, 3));
            stall_flag = s; branch_taken = b; branch_target = t;
            #1;
            exp_st = m_boot || m_halt || m_wait || s || (m_pc == 32'd100);
            if (m_boot || m_halt || m_wait || s || (m_pc != 32'd100)) begin
                total++; if (imem_stall !== exp_st) begin bad++; $display("FAIL rnd_imem_stall: cyc %0d got %0b want %0b", i, imem_stall, exp_st); end
            end
            model_step(s, b, t);
            @(negedge clk);
        end
        stall_flag = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++) wmem[i] = 32'(i);
        @(negedge clk);
        w_rst_n = 1'b1; #1;
        total++; if (w_pc !== 32'd0 || w_imem_stall !== 1'b1) begin bad++; $display("FAIL wrap_boot: got pc %0h stall %0b want 0/1", w_pc, w_imem_stall); end
        for (int j = 0; j <= 4; j++) begin
            @(negedge clk);
            total++; if (w_pc !== 32'((4 * j) % 16)) begin bad++; $display("FAIL wrap_pc: step %0d got %0d want %0d", j, w_pc, (4 * j) % 16); end
            if (j >= 1) begin
                total++; if (w_valid !== 1'b1 || w_ifid_pc !== 32'(4 * (j - 1)) || w_ifid_instn !== 32'(j - 1)) begin
                    bad++; $display("FAIL wrap_deliver: step %0d got v%0b pc %0d instn %0d want 1/%0d/%0d", j, w_valid, w_ifid_pc, w_ifid_instn, 4 * (j - 1), j - 1);
                end
            end
        end
        total++; if (w_count !== 32'd3) begin bad++; $display("FAIL wrap_count: got %0d want 3", w_count); end
        w_stall = 1'b1;
        @(negedge clk); @(negedge clk);
        #2 w_rst_n = 1'b0; #1;
        total++; if (w_pc !== 32'd0 || w_valid !== 1'b0 || w_ifid_pc !== 32'd0 || w_ifid_instn !== 32'd0) begin
            bad++; $display("FAIL wrap_async_reset: got pc %0d v%0b ifid_pc %0d instn %0h want 0/0/0/0", w_pc, w_valid, w_ifid_pc, w_ifid_instn);
        end
        total++; if (w_halted !== 1'b0 || w_mis !== 1'b0 || w_count !== 32'd0 || w_imem_stall !== 1'b1) begin
            bad++; $display("FAIL wrap_async_flags: got h%0b e%0b cnt %0d st %0b want 0/0/0/1", w_halted, w_mis, w_count, w_imem_stall);
        end
        w_stall = 1'b0;
    endtask

    initial begin
        w_rst_n = 1'b0; w_stall = 1'b0; w_br = 1'b0; w_tgt = 32'd0;
        test_reset();
        test_free_run();
        test_stall();
        test_branch();
        test_misaligned();
        test_halt();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
